// File: rtl/seg_count_display.sv
// seg_count_display
//   Prescaled up/down BCD counter with a multiplexed 7-segment display driver.
//   A prescaler generates a count tick every PRESCALE_MAX+1 enabled cycles.
//   On each tick the BCD value steps up or down. It wraps between 0 and
//   COUNT_MAX and pulses `wrap` for one cycle. A free-running scan divider
//   rotates through the digits to drive a time-multiplexed display.
//
//   Optional feature: define LEADING_ZERO_BLANK_EN to blank every digit above
//   the most-significant nonzero digit. Digit 0 is never blanked.
//
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   en       : count enable (prescaler holds when low)
//   up       : direction, 1 = increment, 0 = decrement
//   load     : synchronous load strobe, has priority over tick
//   load_val : BCD load value, digit 0 in [3:0]; illegal values clamp to COUNT_MAX
//   value    : current BCD count (registered)
//   wrap     : one-cycle pulse on roll-over / roll-under
//   seg_out  : segments a..g in [0]..[6], active-high (registered)
//   dp       : decimal point, lit on digit 0 while paused (en=0)
//   dig_sel  : one-hot active-high digit enable (registered)
module seg_count_display #(
    parameter int PRESCALE_MAX = 10000000,
    parameter int DIGITS       = 2,
    parameter int COUNT_MAX    = 99,
    parameter int SCAN_DIV     = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   value,
    output logic                  wrap,
    output logic [6:0]            seg_out,
    output logic                  dp,
    output logic [DIGITS-1:0]     dig_sel
);
    localparam int PW = (PRESCALE_MAX > 0) ? $clog2(PRESCALE_MAX + 1) : 1;
    localparam int SW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;

    function automatic logic [VW-1:0] to_bcd(input int v);
        logic [VW-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // COUNT_MAX in BCD. With all digits legal, comparing BCD words as
    // unsigned binary gives the same order as comparing the decimal values.
    localparam logic [VW-1:0] MAX_BCD = to_bcd(COUNT_MAX);

    function automatic logic [6:0] hex7(input logic [3:0] d);
        case (d)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    logic [PW-1:0]     presc_q, presc_d;
    logic [VW-1:0]     value_q, value_d;
    logic              wrap_q, wrap_d;
    logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
    logic [IW-1:0]     scan_idx_q, scan_idx_d;
    logic [DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic [6:0]        seg_q, seg_d;

    logic              tick;
    logic              load_ok;
    logic [VW-1:0]     bcd_inc, bcd_dec;
    logic              carry, borrow;
    logic [3:0]        cur_digit;
    logic [IW-1:0]     msd;
    logic              scan_adv;

    // BCD +1 / -1 with ripple carry/borrow across digits.
    always_comb begin
        bcd_inc = value_q;
        bcd_dec = value_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value_q[4*i +: 4] == 4'd9) begin
                    bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    bcd_inc[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (value_q[4*i +: 4] == 4'd0) begin
                    bcd_dec[4*i +: 4] = 4'd9;
                end else begin
                    bcd_dec[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // The load value is accepted only if every digit is legal BCD and the
    // value does not exceed COUNT_MAX.
    always_comb begin
        load_ok = (load_val <= MAX_BCD);
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
        end
    end

    always_comb begin
        presc_d = presc_q;
        value_d = value_q;
        wrap_d  = 1'b0;
        tick    = en && (presc_q == PW'(PRESCALE_MAX));
        if (load) begin
            presc_d = '0;
            value_d = load_ok ? load_val : MAX_BCD;
        end else if (en) begin
            if (tick) begin
                presc_d = '0;
                if (up) begin
                    if (value_q == MAX_BCD) begin
                        value_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        value_d = bcd_inc;
                    end
                end else begin
                    if (value_q == '0) begin
                        value_d = MAX_BCD;
                        wrap_d  = 1'b1;
                    end else begin
                        value_d = bcd_dec;
                    end
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // The scan runs regardless of en, so the display stays lit while paused.
    always_comb begin
        scan_adv   = (scan_cnt_q == SW'(SCAN_DIV));
        scan_cnt_d = scan_adv ? '0 : scan_cnt_q + 1'b1;
        scan_idx_d = scan_idx_q;
        if (scan_adv) begin
            scan_idx_d = (scan_idx_q == IW'(DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
        end
    end

    // dig_sel and seg_out are both registered from the current scan index,
    // so the selected digit and its pattern change on the same edge.
    always_comb begin
        cur_digit = value_q[3:0];
        dig_sel_d = '0;
        msd       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx_q == IW'(i)) begin
                cur_digit    = value_q[4*i +: 4];
                dig_sel_d[i] = 1'b1;
            end
            if (value_q[4*i +: 4] != 4'd0) msd = IW'(i);
        end
`ifdef LEADING_ZERO_BLANK_EN
        seg_d = (scan_idx_q > msd) ? 7'h00 : hex7(cur_digit);
`else
        seg_d = hex7(cur_digit);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            value_q    <= '0;
            wrap_q     <= 1'b0;
            scan_cnt_q <= '0;
            scan_idx_q <= '0;
            dig_sel_q  <= DIGITS'(1);
            seg_q      <= 7'b0111111;
        end else begin
            presc_q    <= presc_d;
            value_q    <= value_d;
            wrap_q     <= wrap_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            dig_sel_q  <= dig_sel_d;
            seg_q      <= seg_d;
        end
    end

    assign value   = value_q;
    assign wrap    = wrap_q;
    assign seg_out = seg_q;
    assign dig_sel = dig_sel_q;
    // Paused indicator. rst gates it so the pin reads 0 during reset,
    // even though dig_sel then selects digit 0.
    assign dp      = dig_sel_q[0] & ~en & ~rst;

endmodule

// File: doc/seg_count_display.md
SEG_COUNT_DISPLAY -- requirements
Module: seg_count_display

Interface
REQ-001 SHALL have parameter PRESCALE_MAX, default 10000000: count tick every PRESCALE_MAX+1 enabled cycles.
REQ-002 SHALL have parameter DIGITS, default 2: number of BCD digits, legal range 1..4.
REQ-003 SHALL have parameter COUNT_MAX, default 99: highest count value, decimal, below 10^DIGITS.
REQ-004 SHALL have parameter SCAN_DIV, default 1000: digit-scan advance every SCAN_DIV+1 cycles.
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port clk, input, 1: rising-edge clock.
REQ-007 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-008 SHALL have port en, input, 1: count enable; prescaler holds when low.
REQ-009 SHALL have port up, input, 1: direction, 1 = increment, 0 = decrement.
REQ-010 SHALL have port load, input, 1: synchronous load strobe.
REQ-011 SHALL have port load_val, input, 4*DIGITS: BCD load value, digit 0 in bits [3:0].
REQ-012 SHALL have port value, output, 4*DIGITS: current BCD count.
REQ-013 SHALL have port wrap, output, 1: one-cycle pulse on roll-over or roll-under.
REQ-014 SHALL have port seg_out, output, 7: segments a..g in bits [0]..[6], active-high.
REQ-015 SHALL have port dp, output, 1: decimal point, active-high.
REQ-016 SHALL have port dig_sel, output, DIGITS: one-hot active-high digit enable.

Function
REQ-017 SHALL increment the prescaler each cycle with en=1 and hold it with en=0; tick asserts in the cycle prescaler==PRESCALE_MAX, and the prescaler returns to 0 on the next edge.
REQ-018 SHALL, on tick with up=1, add 1 in BCD with carry across digits; at value==COUNT_MAX it SHALL go to 0 and pulse wrap.
REQ-019 SHALL, on tick with up=0, subtract 1 in BCD with borrow; at value==0 it SHALL go to COUNT_MAX and pulse wrap.
REQ-020 SHALL give load priority over tick: on load=1, value<=load_val, prescaler<=0, wrap stays 0, regardless of en.
REQ-021 SHALL clamp a load_val with any digit >9 or a value >COUNT_MAX to COUNT_MAX.
REQ-022 SHALL update value and wrap on the clock edge following the tick cycle (1-cycle latency, registered outputs).
REQ-023 SHALL run a scan divider independent of en; every SCAN_DIV+1 cycles the scan index SHALL advance 0..DIGITS-1 and wrap to 0.
REQ-024 SHALL drive dig_sel one-hot at bit scan index and seg_out the registered hex decode (0-9; A-F patterns for illegal codes) of that digit, both updating on the same edge.
REQ-025 SHALL drive dp high only while digit 0 is selected and en=0 (paused indicator).
REQ-026 SHALL, with DIGITS=1, hold dig_sel=1 constantly.

Reset
REQ-027 SHALL, while rst=1, asynchronously force prescaler=0, scan index=0, value=0, wrap=0, dig_sel=one-hot bit 0, seg_out=7'b0111111 (digit 0), dp=0.
REQ-028 SHALL discard any in-progress tick or load when rst asserts mid-operation; counting resumes from 0 with a full prescale period after release.

Configuration
REQ-029 SHALL support macro LEADING_ZERO_BLANK_EN: when defined, any selected digit above the most-significant nonzero digit SHALL drive seg_out=0 (digit 0 never blanked); when undefined, all digits always display.

Verification (PRESCALE_MAX=3, DIGITS=2, COUNT_MAX=12, SCAN_DIV=1)
REQ-030 SHALL check: rst pulse then en=1,up=1 for 16 cycles -> value steps 00,01,02,03,04 every 4 cycles, wrap=0.
REQ-031 SHALL check: load_val=0x12, then en=1,up=1 for 4 cycles -> value=0x00, wrap high exactly one cycle.
REQ-032 SHALL check: load_val=0x00, en=1,up=0 for 4 cycles -> value=0x12, wrap pulse; load_val=0x3A -> value=0x12.
REQ-033 SHALL check: value=0x09, en held low 20 cycles -> value unchanged, dp=1 whenever dig_sel=2'b01; load with en=0 still loads.
REQ-034 SHALL check: value=0x07 -> dig_sel alternates 01/10 every 2 cycles; seg_out=0x07 (7) with 01, 0x3F (0) with 10; 0x00 with 10 under LEADING_ZERO_BLANK_EN.
REQ-035 SHALL check: rst asserted mid-prescale between clock edges -> all outputs at reset values immediately, before next clk edge.
